// File: rtl/lock_pkg.sv
`default_nettype none
// ============================================================================
// Module      : lock_pkg
// Description : Constants and types shared by code_entry and the downstream
//               lock FSM: code length, digit width, power-up code and the
//               position type.
// Revision    : 1.0 - initial release
// ============================================================================
package lock_pkg;

    localparam int CODE_LEN = 3;
    localparam int DIGIT_W  = 4;

    // Digit 0 sits in the least significant nibble: code 1,2,3.
    localparam logic [CODE_LEN*DIGIT_W-1:0] DEFAULT_CODE = {4'd3, 4'd2, 4'd1};

    // Needs to hold 0..CODE_LEN inclusive; CODE_LEN means unlocked.
    typedef logic [$clog2(CODE_LEN+1)-1:0] position_t;
    typedef logic [DIGIT_W-1:0]            digit_t;

    function automatic digit_t default_digit(input int idx);
        return DEFAULT_CODE[idx*DIGIT_W +: DIGIT_W];
    endfunction

endpackage
`default_nettype wire

// File: rtl/btn_debounce.sv
`default_nettype none
// ============================================================================
// Module      : btn_debounce
// Description : Two-flop synchronizer followed by a debouncer. The debounced
//               level follows the synchronized input only after
//               DEBOUNCE_CYCLES equal consecutive samples. press is a
//               registered one-cycle pulse on each rising edge of the level.
// Ports       : clk     - system clock, rising edge
//               reset   - asynchronous, active-high
//               btn_raw - raw asynchronous pushbutton
//               press   - one-cycle pulse per debounced press
// Revision    : 1.0 - initial release
// ============================================================================
module btn_debounce #(
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic btn_raw,
    output logic press
);

    localparam int C_CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [C_CNT_W-1:0] C_CNT_LAST = C_CNT_W'(DEBOUNCE_CYCLES - 1);

    logic               r_sync1;
    logic               r_sync2;
    logic               r_level;
    logic               r_press;
    logic [C_CNT_W-1:0] r_cnt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
            r_level <= 1'b0;
            r_press <= 1'b0;
            r_cnt   <= '0;
        end else begin
            r_sync1 <= btn_raw;
            r_sync2 <= r_sync1;
            r_press <= 1'b0;
            // r_cnt counts samples that disagree with the current level; any
            // agreeing sample restarts the run, so short glitches are dropped.
            if (r_sync2 == r_level) begin
                r_cnt <= '0;
            end else if (r_cnt == C_CNT_LAST) begin
                r_level <= r_sync2;
                r_press <= r_sync2;
                r_cnt   <= '0;
            end else begin
                r_cnt <= r_cnt + C_CNT_W'(1);
            end
        end
    end

    assign press = r_press;

endmodule
`default_nettype wire

// File: rtl/code_entry.sv
`default_nettype none
// ============================================================================
// Module      : code_entry
// Description : Debounced keypad-style code entry. Each press of the enter
//               button compares digit_sw against the stored code digit,
//               tracks progress, locks out after too many wrong digits and
//               allows reprogramming the code while unlocked.
// Ports       : clk, reset     - clock / asynchronous active-high reset
//               btn_raw        - raw enter pushbutton
//               digit_sw[3:0]  - digit switches, sampled on press
//               prog_en        - reprogram request while unlocked
//               enter          - one-cycle press pulse to downstream FSM
//               correct_digit  - digit matched; valid with enter
//               position[1:0]  - digits accepted, CODE_LEN = unlocked
//               lockout        - presses ignored
//               prog_done      - one-cycle pulse when new code complete
// Revision    : 1.0 - initial release
// ============================================================================
module code_entry
    import lock_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int LOCKOUT_CYCLES  = 16,
    parameter int MAX_ERRORS      = 3
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  btn_raw,
    input  logic [DIGIT_W-1:0]    digit_sw,
    input  logic                  prog_en,
    output logic                  enter,
    output logic                  correct_digit,
    output position_t             position,
    output logic                  lockout,
    output logic                  prog_done
);

    localparam int C_LOCK_W = (LOCKOUT_CYCLES > 1) ? $clog2(LOCKOUT_CYCLES) : 1;
    localparam logic [C_LOCK_W-1:0] C_LOCK_LAST = C_LOCK_W'(LOCKOUT_CYCLES - 1);
    localparam int C_ERR_W = $clog2(MAX_ERRORS + 1);
    localparam logic [C_ERR_W-1:0] C_ERR_MAX = C_ERR_W'(MAX_ERRORS);
    localparam position_t C_UNLOCKED = position_t'(CODE_LEN);
    localparam position_t C_LAST_IDX = position_t'(CODE_LEN - 1);

    logic                w_press;
    logic                w_blocked;
    logic                w_match;
    digit_t              w_exp_digit;

    digit_t              r_code [CODE_LEN];
    position_t           r_position;
    position_t           r_prog_idx;
    logic [C_ERR_W-1:0]  r_errors;
    logic [C_LOCK_W-1:0] r_lock_cnt;
    logic                r_lockout;
    logic                r_enter;
    logic                r_correct;
    logic                r_prog_done;

    btn_debounce #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_btn_debounce (
        .clk     (clk),
        .reset   (reset),
        .btn_raw (btn_raw),
        .press   (w_press)
    );

    always_comb begin
        w_exp_digit = r_code[0];
        for (int i = 1; i < CODE_LEN; i++) begin
            if (r_position == position_t'(i)) begin
                w_exp_digit = r_code[i];
            end
        end
    end

    assign w_match   = (digit_sw == w_exp_digit);
    // The error count reaches its limit one cycle before lockout rises;
    // presses in that gap must already be ignored.
    assign w_blocked = r_lockout || (r_errors >= C_ERR_MAX);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < CODE_LEN; i++) begin
                r_code[i] <= default_digit(i);
            end
            r_position  <= '0;
            r_prog_idx  <= '0;
            r_errors    <= '0;
            r_lock_cnt  <= '0;
            r_lockout   <= 1'b0;
            r_enter     <= 1'b0;
            r_correct   <= 1'b0;
            r_prog_done <= 1'b0;
        end else begin
            r_enter     <= 1'b0;
            r_correct   <= 1'b0;
            r_prog_done <= 1'b0;

            // Leaving program mode abandons a partial code but keeps digits
            // already written.
            if (!prog_en) begin
                r_prog_idx <= '0;
            end

            // Lockout timer: stops at its last value and ends the lockout
            // there, so it never wraps.
            if (r_lockout) begin
                if (r_lock_cnt == C_LOCK_LAST) begin
                    r_lockout <= 1'b0;
                    r_errors  <= '0;
                end else begin
                    r_lock_cnt <= r_lock_cnt + C_LOCK_W'(1);
                end
            end else if (r_errors >= C_ERR_MAX) begin
                r_lockout  <= 1'b1;
                r_lock_cnt <= '0;
            end

            if (w_press && !w_blocked) begin
                if (r_position == C_UNLOCKED) begin
                    if (prog_en) begin
                        for (int i = 0; i < CODE_LEN; i++) begin
                            if (r_prog_idx == position_t'(i)) begin
                                r_code[i] <= digit_sw;
                            end
                        end
                        if (r_prog_idx == C_LAST_IDX) begin
                            r_prog_done <= 1'b1;
                            r_prog_idx  <= '0;
                        end else begin
                            r_prog_idx <= r_prog_idx + position_t'(1);
                        end
                    end else begin
                        // Relocking press: downstream FSM follows S3->S0.
                        r_enter    <= 1'b1;
                        r_position <= '0;
                    end
                end else begin
                    r_enter   <= 1'b1;
                    r_correct <= w_match;
                    if (w_match) begin
                        r_position <= r_position + position_t'(1);
                        if (r_position == C_LAST_IDX) begin
                            r_errors <= '0;
                        end
                    end else begin
                        r_position <= '0;
                        r_errors   <= r_errors + C_ERR_W'(1);
                    end
                end
            end
        end
    end

    assign enter         = r_enter;
    assign correct_digit = r_correct;
    assign position      = r_position;
    assign lockout       = r_lockout;
    assign prog_done     = r_prog_done;

endmodule
`default_nettype wire

// File: tb/tb_code_entry.sv
`default_nettype none
// ============================================================================
// Module      : tb_code_entry
// Description : Self-checking bench for code_entry. A press-level reference
//               model predicts each press outcome (enter pulse, its edge,
//               correct_digit, position, prog_done) and the lockout window.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_code_entry;

    localparam int DEB  = 4;
    localparam int LOCK = 16;
    localparam int MAXE = 3;

    logic       clk = 1'b0;
    logic       reset;
    logic       btn_raw;
    logic [3:0] digit_sw;
    logic       prog_en;
    logic       enter;
    logic       correct_digit;
    logic [1:0] position;
    logic       lockout;
    logic       prog_done;

    code_entry #(
        .DEBOUNCE_CYCLES (DEB),
        .LOCKOUT_CYCLES  (LOCK),
        .MAX_ERRORS      (MAXE)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .btn_raw       (btn_raw),
        .digit_sw      (digit_sw),
        .prog_en       (prog_en),
        .enter         (enter),
        .correct_digit (correct_digit),
        .position      (position),
        .lockout       (lockout),
        .prog_done     (prog_done)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        if (obs !== exp) begin
            miscompares++;
            $display("FAIL %s: observed %0d expected %0d (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Reference model state
    int m_code [3];
    int m_pos, m_errs, m_idx;
    int m_lock_start, m_lock_end;   // lockout visible on edges [start, start+LOCK)

    // Edge counter and pulse monitor
    int cyc = 0;
    int n_enter, enter_cyc, enter_cd, enter_pos, n_pd, pd_cyc;
    bit mon_on = 1'b0;

    task automatic model_reset();
        m_code[0] = 1; m_code[1] = 2; m_code[2] = 3;
        m_pos = 0; m_errs = 0; m_idx = 0;
        m_lock_start = -1000; m_lock_end = -1000;
    endtask

    initial begin
        forever begin
            @(posedge clk);
            cyc++;
            #1;
            if (enter === 1'b1) begin
                n_enter++; enter_cyc = cyc; enter_cd = correct_digit; enter_pos = position;
            end
            if (prog_done === 1'b1) begin
                n_pd++; pd_cyc = cyc;
            end
            if (mon_on)
                check("lockout", lockout, (cyc >= m_lock_start && cyc < m_lock_start + LOCK));
        end
    end

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1; btn_raw = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
        check("rst_enter", enter, 0);
        check("rst_correct", correct_digit, 0);
        check("rst_prog_done", prog_done, 0);
        check("rst_lockout", lockout, 0);
        check("rst_position", position, 0);
        reset = 1'b0;
    endtask

    task automatic set_prog(input bit b);
        @(negedge clk);
        prog_en = b;
        if (!b) m_idx = 0;
    endtask

    // One press of digit d: optional 1-cycle bounce glitches before the
    // clean rise, optional 1-cycle dip while held.
    task automatic press(input int d, input int glitches, input int extra, input bit dip);
        int  s, ev, exp_pos;
        bit  exp_enter, exp_cd, exp_pd;
        digit_sw = d[3:0];
        n_enter = 0; n_pd = 0;
        @(negedge clk);
        for (int g = 0; g < glitches; g++) begin
            btn_raw = 1'b1; @(negedge clk);
            btn_raw = 1'b0; @(negedge clk);
        end
        btn_raw = 1'b1;
        s  = cyc + 1;          // first edge sampling the clean high level
        ev = s + DEB + 2;      // edge at which enter must assert
        exp_enter = 0; exp_cd = 0; exp_pd = 0;
        if (ev <= m_lock_end) begin
            // discarded during lockout
        end else if (m_pos == 3 && prog_en) begin
            m_code[m_idx] = d;
            if (m_idx == 2) begin exp_pd = 1; m_idx = 0; end
            else m_idx++;
        end else if (m_pos == 3) begin
            exp_enter = 1; m_pos = 0;
        end else begin
            exp_enter = 1;
            exp_cd = (d == m_code[m_pos]);
            if (exp_cd) begin
                m_pos++;
                if (m_pos == 3) m_errs = 0;
            end else begin
                m_pos = 0; m_errs++;
                if (m_errs == MAXE) begin
                    m_errs = 0;
                    m_lock_start = ev + 1;
                    m_lock_end   = ev + LOCK + 1;
                end
            end
        end
        exp_pos = m_pos;
        repeat (DEB + 3 + extra) @(negedge clk);
        if (dip) begin
            btn_raw = 1'b0; @(negedge clk);
            btn_raw = 1'b1; repeat (3) @(negedge clk);
        end
        btn_raw = 1'b0;
        repeat (DEB + 5) @(negedge clk);
        check("enter_count", n_enter, exp_enter);
        if (exp_enter && n_enter == 1) begin
            check("enter_edge", enter_cyc, ev);
            check("correct_digit", enter_cd, exp_cd);
            check("pos_at_enter", enter_pos, exp_pos);
        end
        check("prog_done_count", n_pd, exp_pd);
        if (exp_pd && n_pd == 1) check("prog_done_edge", pd_cyc, ev);
        check("position", position, exp_pos);
    endtask

    initial begin
        reset = 1'b1; btn_raw = 1'b0; prog_en = 1'b0; digit_sw = 4'd0;
        model_reset();
        do_reset();
        mon_on = 1'b1;

        // Clean entry of the default code, then a relocking press
        press(1, 0, 0, 0); press(2, 0, 0, 0); press(3, 0, 0, 0);
        press(9, 0, 0, 0);
        // Bouncy press, then a wrong second digit
        press(1, 3, 0, 1);
        press(5, 0, 0, 0);

        // Three wrong digits, a press inside the lockout, one after it
        do_reset();
        press(4, 0, 0, 0); press(4, 0, 0, 0); press(4, 0, 0, 0);
        press(1, 0, 0, 0);
        repeat (8) @(negedge clk);
        press(1, 0, 0, 0);

        // Reprogramming to 7,0,9
        do_reset();
        press(1, 0, 0, 0); press(2, 0, 0, 0); press(3, 0, 0, 0);
        set_prog(1);
        press(7, 0, 0, 0); press(0, 0, 0, 0); press(9, 0, 0, 0);
        set_prog(0);
        press(4, 0, 0, 0);
        press(7, 0, 0, 0); press(0, 0, 0, 0); press(9, 0, 0, 0);
        // prog_en dropped mid-programming restarts at digit 0
        set_prog(1);
        press(5, 0, 0, 0);
        set_prog(0); set_prog(1);
        press(6, 0, 0, 0); press(8, 0, 0, 0); press(2, 0, 0, 0);
        set_prog(0);
        press(1, 0, 0, 0);
        press(6, 0, 0, 0); press(8, 0, 0, 0); press(2, 0, 0, 0);

        // Reset during lockout restores the default code
        do_reset();
        press(0, 0, 0, 0); press(0, 0, 0, 0); press(0, 0, 0, 0);
        repeat (3) @(negedge clk);
        do_reset();
        press(1, 0, 0, 0); press(2, 0, 0, 0); press(3, 0, 0, 0);

        // Randomized presses
        for (int n = 0; n < 80; n++) begin
            int d;
            if ($urandom_range(0, 99) < 3) do_reset();
            if (m_pos == 3 && $urandom_range(0, 3) == 0) set_prog(!prog_en);
            if (m_pos < 3 && $urandom_range(0, 99) < 65) d = m_code[m_pos];
            else d = $urandom_range(0, 15);
            press(d, $urandom_range(0, 2), $urandom_range(0, 4), 1'($urandom_range(0, 1)));
            if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 12)) @(negedge clk);
        end

        mon_on = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/code_entry.md
CODE_ENTRY -- requirements
Module: code_entry

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 4: consecutive stable synchronized samples before the debounced level changes.
REQ-002 Parameter LOCKOUT_CYCLES, default 16: lockout duration in clk cycles.
REQ-003 Parameter MAX_ERRORS, default 3: wrong digits that trigger lockout.
REQ-004 clk  input  1  system clock; all flops on rising edge.
REQ-005 reset  input  1  asynchronous, active-high reset.
REQ-006 btn_raw  input  1  raw, asynchronous, bouncing enter pushbutton.
REQ-007 digit_sw  input  4  digit switches, quasi-static, sampled on press.
REQ-008 prog_en  input  1  request to reprogram the code while unlocked.
REQ-009 enter  output  1  one-cycle press pulse to the downstream lock FSM.
REQ-010 correct_digit  output  1  digit_sw matches the expected code digit; valid only while enter=1.
REQ-011 position  output  2  digits accepted so far, 0..CODE_LEN; CODE_LEN means unlocked.
REQ-012 lockout  output  1  high while presses are ignored after too many errors.
REQ-013 prog_done  output  1  one-cycle pulse when the last digit of a new code is stored.

Function
REQ-014 btn_raw SHALL pass through a 2-flop synchronizer, then a debouncer that updates its level only after DEBOUNCE_CYCLES equal consecutive samples.
REQ-015 A press event SHALL be the rising edge of the debounced level; a held button SHALL yield exactly one event.
REQ-016 For a clean press, enter SHALL assert at the 3+DEBOUNCE_CYCLES-th rising edge after btn_raw is first sampled high.
REQ-017 Bounces shorter than DEBOUNCE_CYCLES SHALL produce no event.
REQ-018 Code SHALL be CODE_LEN=3 digits of 4 bits, initialised to DEFAULT_CODE = 1,2,3 (digit 0 first).
REQ-019 Normal mode (position<CODE_LEN, lockout=0): each event SHALL pulse enter with correct_digit = (digit_sw == code[position]).
REQ-020 Correct event SHALL increment position.
REQ-021 Wrong event SHALL clear position to 0 and increment the error counter.
REQ-022 Unlocked (position==CODE_LEN, prog_en=0): an event SHALL pulse enter with correct_digit=0 and clear position to 0, keeping downstream S3->S0 in lockstep.
REQ-023 Program mode (position==CODE_LEN and prog_en=1 at the event): enter SHALL stay 0, digit_sw SHALL be written to code[prog_idx], and prog_idx SHALL increment.
REQ-024 Program mode, third write: prog_done SHALL pulse in the same cycle, prog_idx SHALL clear, and position SHALL stay CODE_LEN.
REQ-025 prog_en deasserting mid-programming SHALL clear prog_idx and keep the digits already written.
REQ-026 When the error counter reaches MAX_ERRORS, lockout SHALL assert the next cycle for exactly LOCKOUT_CYCLES cycles.
REQ-027 During lockout, events SHALL be discarded (no enter, no state change); on exit, the error counter SHALL clear.
REQ-028 Reaching position==CODE_LEN SHALL clear the error counter.
REQ-029 The lockout counter SHALL saturate and never wrap.
REQ-030 Events and outputs SHALL use single-cycle registered logic; enter, correct_digit and prog_done SHALL be registered.

Reset
REQ-031 Reset SHALL drive enter=0, correct_digit=0, prog_done=0, lockout=0, position=0, debounced level=0, synchronizer=0, all counters=0.
REQ-032 Reset SHALL restore code to DEFAULT_CODE; reset mid-debounce, mid-lockout or mid-programming SHALL abandon that activity with no pulse.

Structure
REQ-033 Package lock_pkg SHALL hold CODE_LEN, DIGIT_W=4, DEFAULT_CODE and the position type, shared with the downstream FSM.
REQ-034 Synchronizer and debouncer SHALL form sub-module btn_debounce (clk, reset, btn_raw -> press pulse), parameterised by DEBOUNCE_CYCLES.

Verification
REQ-035 Clean press of 1,2,3 -> three enter pulses, correct_digit=1 each, position 1,2,3.
REQ-036 Press with 1-cycle bounce glitches -> exactly one enter pulse at the latency given in REQ-016.
REQ-037 Press 1 then 5 -> second pulse has correct_digit=0 and position=0.
REQ-038 Three wrong digits -> lockout=1 for 16 cycles; a press inside that window gives no enter; a press after it is accepted.
REQ-039 Unlock, prog_en=1, enter 7,0,9 -> no enter pulses, prog_done once; then prog_en=0, press -> position 0; 7,0,9 -> position 3.
REQ-040 Assert reset during lockout and after reprogramming -> lockout=0, position=0, code 1,2,3 unlocks.
